// File: rtl/fm_synth_pkg.sv
// Shared types for the FM synth voice path: keycode width, allocator FSM states.
package fm_synth_pkg;

    localparam int NUM_VOICES_DEF = 4;

    typedef logic [7:0] keycode_t;

    typedef enum logic [1:0] {
        IDLE,
        MATCH,
        COMMIT
    } alloc_state_t;

    localparam keycode_t KEY_NONE = 8'h00;

endpackage

// File: rtl/voice_match_encoder.sv
// Compares the pending event code against every voice and picks the hit,
// lowest free and oldest voices.
module voice_match_encoder
    import fm_synth_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    localparam int IW = $clog2(NUM_VOICES)
) (
    input  logic [0:NUM_VOICES-1][7:0]    keycodes,
    input  logic [0:NUM_VOICES-1]         rden,
    input  logic [0:NUM_VOICES-1][IW-1:0] ages,
    input  logic [7:0]                    code,
    output logic [0:NUM_VOICES-1]         hit_vec,
    output logic [0:NUM_VOICES-1]         free_vec,
    output logic [IW-1:0]                 hit_idx,
    output logic [IW-1:0]                 free_idx,
    output logic [IW-1:0]                 old_idx
);

    genvar g;
    generate
        for (g = 0; g < NUM_VOICES; g++) begin : g_cmp
            assign hit_vec[g]  = rden[g] && (keycodes[g] == code);
            assign free_vec[g] = !rden[g];
        end
    endgenerate

    logic [IW-1:0] best_age;

    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        // Walk high to low so the lowest matching index is the last one written.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (hit_vec[v])  hit_idx  = IW'(v);
            if (free_vec[v]) free_idx = IW'(v);
        end
    end

    always_comb begin
        old_idx  = '0;
        best_age = ages[0];
        // Strict compare keeps the lowest index on an age tie.
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (ages[v] > best_age) begin
                best_age = ages[v];
                old_idx  = IW'(v);
            end
        end
    end

endmodule

// File: rtl/keycode_voice_allocator.sv
// Maps keyboard make/break events onto a fixed pool of synth voices, stealing
// the oldest voice when the pool is full. One event per three-cycle pass.
module keycode_voice_allocator
    import fm_synth_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         key_valid,
    input  logic [7:0]                   key_code,
    input  logic                         key_release,
    output logic                         key_ready,
    output logic [0:NUM_VOICES-1][7:0]   keycodes,
    output logic [0:NUM_VOICES-1]        rden,
    output logic [0:NUM_VOICES-1]        note_on
);

    localparam int IW = $clog2(NUM_VOICES);
    localparam logic [IW-1:0] AGE_MAX = IW'(NUM_VOICES - 1);

    alloc_state_t state, state_nxt;

    keycode_t ev_code;
    logic     ev_brk;

    logic [0:NUM_VOICES-1]         hit_vec, free_vec, hit_vec_q, free_vec_q;
    logic [IW-1:0]                 hit_idx, free_idx, old_idx;
    logic [IW-1:0]                 hit_idx_q, free_idx_q, steal_idx_q;
    logic [0:NUM_VOICES-1][IW-1:0] ages;

    logic          accept;
    logic          do_assign, do_rel;
    logic [IW-1:0] tgt;

    // Gating with reset_n keeps ready low for the whole reset window.
    assign key_ready = reset_n && (state == IDLE);
    assign accept    = key_valid && key_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MATCH;
            MATCH:   state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ev_code <= KEY_NONE;
            ev_brk  <= 1'b0;
        end else if (accept) begin
            ev_code <= key_code;
            ev_brk  <= key_release;
        end
    end

    voice_match_encoder #(.NUM_VOICES(NUM_VOICES)) u_enc (
        .keycodes (keycodes),
        .rden     (rden),
        .ages     (ages),
        .code     (ev_code),
        .hit_vec  (hit_vec),
        .free_vec (free_vec),
        .hit_idx  (hit_idx),
        .free_idx (free_idx),
        .old_idx  (old_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_vec_q   <= '0;
            free_vec_q  <= '0;
            hit_idx_q   <= '0;
            free_idx_q  <= '0;
            steal_idx_q <= '0;
        end else if (state == MATCH) begin
            hit_vec_q   <= hit_vec;
            free_vec_q  <= free_vec;
            hit_idx_q   <= hit_idx;
            free_idx_q  <= free_idx;
            steal_idx_q <= old_idx;
        end
    end

    always_comb begin
        do_assign = 1'b0;
        do_rel    = 1'b0;
        tgt       = '0;
        if (state == COMMIT && ev_code != KEY_NONE) begin
            if (ev_brk) begin
                do_rel = |hit_vec_q;
                tgt    = hit_idx_q;
            end else if (!(|hit_vec_q)) begin
                do_assign = 1'b1;
                tgt       = (|free_vec_q) ? free_idx_q : steal_idx_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            keycodes <= '0;
            rden     <= '0;
            note_on  <= '0;
            ages     <= '0;
        end else begin
            note_on <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (do_assign) begin
                    if (IW'(v) == tgt) begin
                        keycodes[v] <= ev_code;
                        rden[v]     <= 1'b1;
                        note_on[v]  <= 1'b1;
                        ages[v]     <= '0;
                    end else if (ages[v] != AGE_MAX) begin
                        ages[v] <= ages[v] + 1'b1;
                    end
                end else if (do_rel && IW'(v) == tgt) begin
                    rden[v] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keycode_voice_allocator.sv
// Scoreboarded bench: a behavioural voice model pushes the expected post-commit
// outputs for every event; each scenario pops and compares.
module tb_keycode_voice_allocator;

    localparam int NV = 4;

    typedef struct packed {
        logic [0:NV-1][7:0] kc;
        logic [0:NV-1]      rden;
        logic [0:NV-1]      non;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 key_valid = 1'b0;
    logic [7:0]           key_code = 8'h00;
    logic                 key_release = 1'b0;
    logic                 key_ready;
    logic [0:NV-1][7:0]   keycodes;
    logic [0:NV-1]        rden;
    logic [0:NV-1]        note_on;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    logic [7:0]    m_kc[NV];
    logic [0:NV-1] m_rden;
    int            m_age[NV];

    keycode_voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_release (key_release),
        .key_ready   (key_ready),
        .keycodes    (keycodes),
        .rden        (rden),
        .note_on     (note_on)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int v = 0; v < NV; v++) begin
            m_kc[v]  = 8'h00;
            m_age[v] = 0;
        end
        m_rden = '0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    // Drive one event through the handshake and push the model's expectation.
    task automatic send(input logic [7:0] code, input logic brk);
        exp_t e;
        int   hit, tgt, n;
        n = 0;
        @(negedge clk);
        while (!key_ready) begin
            n++;
            if (n > 20) begin
                errors++;
                $display("FAIL ready_timeout got 0 exp 1");
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "ready timeout");
            end
            @(negedge clk);
        end
        key_valid = 1'b1; key_code = code; key_release = brk;
        @(posedge clk);
        #1 key_valid = 1'b0;
        e.non = '0;
        if (code != 8'h00) begin
            hit = -1;
            for (int v = 0; v < NV; v++)
                if (hit < 0 && m_rden[v] && m_kc[v] == code) hit = v;
            if (brk) begin
                if (hit >= 0) m_rden[hit] = 1'b0;
            end else if (hit < 0) begin
                tgt = -1;
                for (int v = 0; v < NV; v++)
                    if (tgt < 0 && !m_rden[v]) tgt = v;
                if (tgt < 0) begin
                    tgt = 0;
                    for (int v = 1; v < NV; v++)
                        if (m_age[v] > m_age[tgt]) tgt = v;
                end
                for (int v = 0; v < NV; v++)
                    m_age[v] = (v == tgt) ? 0 : ((m_age[v] < NV - 1) ? m_age[v] + 1 : NV - 1);
                m_kc[tgt]   = code;
                m_rden[tgt] = 1'b1;
                e.non[tgt]  = 1'b1;
            end
        end
        for (int v = 0; v < NV; v++) e.kc[v] = m_kc[v];
        e.rden = m_rden;
        sb.push_back(e);
    endtask

    // Advance to just after the commit edge of the last accepted event.
    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t got;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = {keycodes, rden, note_on};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", got); end
        checks++;
        if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", key_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", key_ready); end
        model_clear();
    endtask

    task automatic test_single_press();
        exp_t got, e;
        send(8'h1C, 1'b0);
        settle();
        got = {keycodes, rden, note_on}; e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL single_press got %h exp %h", got, e); end
        checks++;
        if (keycodes[0] !== 8'h1C || rden !== 4'b1000 || note_on !== 4'b1000) begin
            errors++; $display("FAIL single_press_const got %h/%b/%b exp 1c/1000/1000", keycodes[0], rden, note_on);
        end
        @(posedge clk); #1;
        checks++;
        if (note_on !== 4'b0000) begin errors++; $display("FAIL note_on_pulse got %b exp 0000", note_on); end
    endtask

    task automatic test_steal();
        exp_t got, e;
        logic [7:0] codes[5] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(codes[i], 1'b0);
            settle();
            got = {keycodes, rden, note_on}; e = sb.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL steal_seq%0d got %h exp %h", i, got, e); end
        end
        checks++;
        if (keycodes[0] !== 8'h34 || rden !== 4'b1111 || note_on !== 4'b1000) begin
            errors++; $display("FAIL steal_oldest got %h/%b/%b exp 34/1111/1000", keycodes[0], rden, note_on);
        end
    endtask

    task automatic test_release();
        exp_t got, e;
        do_reset();
        send(8'h1C, 1'b0); settle(); void'(sb.pop_front());
        send(8'h1C, 1'b1); settle();
        got = {keycodes, rden, note_on}; e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL release_held got %h exp %h", got, e); end
        checks++;
        if (rden !== 4'b0000 || keycodes[0] !== 8'h1C) begin
            errors++; $display("FAIL release_keep got %b/%h exp 0000/1c", rden, keycodes[0]);
        end
        send(8'h55, 1'b1); settle();
        got = {keycodes, rden, note_on}; e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL release_unheld got %h exp %h", got, e); end
        send(8'h00, 1'b0); settle();
        got = {keycodes, rden, note_on}; e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL zero_code got %h exp %h", got, e); end
    endtask

    task automatic test_back_to_back();
        exp_t got, e;
        int rdy;
        do_reset();
        send(8'h1C, 1'b0); settle(); void'(sb.pop_front());
        send(8'h1C, 1'b0); settle();
        got = {keycodes, rden, note_on}; e = sb.pop_front();
        checks++;
        if (got !== e || note_on !== 4'b0000 || rden !== 4'b1000) begin
            errors++; $display("FAIL repeat_press got %h exp %h", got, e);
        end
        @(negedge clk);
        key_valid = 1'b1; key_code = 8'h00; key_release = 1'b0;
        rdy = 0;
        for (int c = 0; c < 12; c++) begin
            if (key_ready) rdy++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rdy !== 4) begin errors++; $display("FAIL ready_rate got %0d exp 4", rdy); end
        got = {keycodes, rden, note_on};
        checks++;
        if (got !== e) begin errors++; $display("FAIL held_zero_stream got %h exp %h", got, e); end
    endtask

    task automatic test_reset_mid();
        exp_t got;
        do_reset();
        send(8'h1C, 1'b0); settle(); void'(sb.pop_front());
        @(negedge clk);
        key_valid = 1'b1; key_code = 8'h1B; key_release = 1'b0;
        @(posedge clk);
        #1 key_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        got = {keycodes, rden, note_on};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL midreset_outputs got %h exp 0", got); end
        reset_n = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b exp 1", key_ready); end
        repeat (3) @(posedge clk);
        #1;
        got = {keycodes, rden, note_on};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL midreset_lost got %h exp 0", got); end
        model_clear();
    endtask

    task automatic test_free_beats_oldest();
        exp_t got, e;
        logic [7:0] codes[4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(codes[i], 1'b0); settle(); void'(sb.pop_front());
        end
        send(8'h23, 1'b1); settle(); void'(sb.pop_front());
        send(8'h42, 1'b0); settle();
        got = {keycodes, rden, note_on}; e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL free_first got %h exp %h", got, e); end
        checks++;
        if (keycodes[2] !== 8'h42 || keycodes[0] !== 8'h1C || note_on !== 4'b0010) begin
            errors++; $display("FAIL free_first_const got %h/%h/%b exp 42/1c/0010", keycodes[2], keycodes[0], note_on);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_steal();
        test_release();
        test_back_to_back();
        test_reset_mid();
        test_free_beats_oldest();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keycode_voice_allocator.md
KEYCODE_VOICE_ALLOCATOR -- requirements
Module: keycode_voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of voice slots; legal range 2..8.
REQ-002 Port clk, input, 1: single clock; all logic on rising edge.
REQ-003 Port reset_n, input, 1: synchronous, active-low reset.
REQ-004 Port key_valid, input, 1: key event present.
REQ-005 Port key_code, input, 8: keyboard keycode of event; 8'h00 is invalid.
REQ-006 Port key_release, input, 1: 1 = key break (note off), 0 = key make (note on).
REQ-007 Port key_ready, output, 1: allocator can accept an event this cycle.
REQ-008 Port keycodes, output, 8 x [0:NUM_VOICES-1]: keycode currently assigned to each voice; feeds the phase-increment lookup stage.
REQ-009 Port rden, output, [0:NUM_VOICES-1]: voice active (key held); feeds lookup read enables.
REQ-010 Port note_on, output, [0:NUM_VOICES-1]: one-cycle pulse when a voice is newly assigned; envelope retrigger.

Function
REQ-011 Handshake: event accepted on a clock edge where key_valid && key_ready; source holds key_code/key_release stable until then.
REQ-012 FSM states IDLE, MATCH, COMMIT; IDLE->MATCH on accept; MATCH->COMMIT unconditionally; COMMIT->IDLE unconditionally.
REQ-013 key_ready = 1 only in IDLE; one event every 3 cycles maximum.
REQ-014 Accept registers event; MATCH registers per-voice hit vector (rden[v] && keycodes[v]==event code), free vector (!rden[v]) and steal index.
REQ-015 COMMIT applies update; keycodes/rden/note_on change at the COMMIT edge, i.e. 3 edges after accept.
REQ-016 Press, code already held in a voice: no state change, no note_on.
REQ-017 Press, not held, a free voice exists: assign lowest-index free voice; keycodes[v] <= code, rden[v] <= 1, note_on[v] pulses 1 cycle.
REQ-018 Press, not held, no free voice: steal voice with greatest age, lowest index on tie; same update as REQ-017.
REQ-019 Age: per-voice counter, width $clog2(NUM_VOICES); on every assignment the assigned voice age <= 0, every other voice age increments, saturating at NUM_VOICES-1.
REQ-020 Release, code held in voice v: rden[v] <= 0; keycodes[v] retained; age unchanged.
REQ-021 Release, code not held (never pressed or already stolen): no change.
REQ-022 key_code 8'h00: accepted (handshake completes) but no state change.
REQ-023 At most one hit per code is guaranteed by REQ-016; if multiple hits occur, lowest index is used.
REQ-024 note_on is zero in every cycle other than the one following COMMIT.

Reset
REQ-025 While reset_n=0 at a clock edge: FSM <= IDLE, keycodes all 8'h00, rden all 0, note_on all 0, ages all 0, event registers cleared.
REQ-026 key_ready = 0 during reset cycles, 1 in first cycle after reset_n rises.
REQ-027 Reset in MATCH or COMMIT discards the in-flight event; no partial update visible.

Structure
REQ-028 Shared package fm_synth_pkg holds NUM_VOICES default, keycode_t (8-bit), alloc_state_t enum (IDLE, MATCH, COMMIT).
REQ-029 One sub-module voice_match_encoder: combinational compare of event code against all voices, plus priority encoders for hit index, lowest free index and oldest-age index.
REQ-030 Implementation 120-400 lines RTL; no memories inferred.

Verification
REQ-031 Reset, then press 8'h1C: after 3 edges keycodes[0]=8'h1C, rden=4'b1000, note_on[0] pulses exactly 1 cycle.
REQ-032 Press 8'h1C, 8'h1B, 8'h23, 8'h2B, then 8'h34: voice 0 (oldest) stolen, keycodes[0]=8'h34, rden=4'b1111, note_on=4'b1000 pulse.
REQ-033 Press 8'h1C then release 8'h1C: rden[0]=0, keycodes[0] stays 8'h1C; release 8'h55 (unheld): outputs unchanged.
REQ-034 Press 8'h1C twice: second press gives no note_on, rden=4'b1000 unchanged; key_valid held high continuously: key_ready high exactly 1 of every 3 cycles.
REQ-035 Assert reset_n=0 during MATCH of press 8'h1B with voice 0 holding 8'h1C: all outputs zero after edge, event lost, key_ready=1 after release of reset.
REQ-036 Fill 4 voices, release voice 2, press 8'h42: assigned to voice 2 (free beats oldest), voice 0 untouched.
